// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one memory port between the instruction-fetch (imem) and data (dmem)
//   requesters. Round-robin grant, one outstanding transaction at a time.
//   A granted request is latched, presented on the shared port until accepted,
//   and the response is returned to the owning requester as a one-cycle pulse.
//
// Ports
//   clk, reset                 clock, asynchronous active-low reset
//   imem_req_*                 fetch request (valid/addr in, ready out)
//   imem_resp_*                fetch response pulse and data
//   dmem_req_*                 data request (valid/addr/fcn/typ/wdata in, ready out)
//   dmem_resp_*                data response pulse and data (reads and writes)
//   mem_req_*                  shared-port request, registered fields
//   mem_resp_*                 shared-port response
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              imem_req_valid,
  input  logic [ADDR_W-1:0] imem_req_addr,
  output logic              imem_req_ready,
  output logic              imem_resp_valid,
  output logic [DATA_W-1:0] imem_resp_data,

  input  logic              dmem_req_valid,
  input  logic [ADDR_W-1:0] dmem_req_addr,
  input  logic              dmem_req_fcn,
  input  logic [2:0]        dmem_req_typ,
  input  logic [DATA_W-1:0] dmem_req_wdata,
  output logic              dmem_req_ready,
  output logic              dmem_resp_valid,
  output logic [DATA_W-1:0] dmem_resp_data,

  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_fcn,
  output logic [2:0]        mem_req_typ,
  output logic [DATA_W-1:0] mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data
);

  localparam logic       M_XRD = 1'b0;
  localparam logic [2:0] MT_WU = 3'd6;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } state_e;

  typedef enum logic {
    SelImem = 1'b0,
    SelDmem = 1'b1
  } sel_e;

  state_e            state_q, state_d;
  sel_e              last_grant_q, last_grant_d;
  sel_e              owner_q, owner_d;

  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              req_fcn_q, req_fcn_d;
  logic [2:0]        req_typ_q, req_typ_d;
  logic [DATA_W-1:0] req_wdata_q, req_wdata_d;

  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic              imem_resp_valid_q, imem_resp_valid_d;
  logic              dmem_resp_valid_q, dmem_resp_valid_d;

  logic              idle;
  logic              grant_imem;
  logic              grant_dmem;

  // Grant depends only on state and request valids; on a tie the requester
  // that did not win last time goes first.
  always_comb begin
    idle       = (state_q == StIdle);
    grant_imem = imem_req_valid & (~dmem_req_valid | (last_grant_q == SelDmem));
    grant_dmem = dmem_req_valid & (~imem_req_valid | (last_grant_q == SelImem));
    imem_req_ready = idle & grant_imem;
    dmem_req_ready = idle & grant_dmem;
  end

  always_comb begin
    state_d           = state_q;
    last_grant_d      = last_grant_q;
    owner_d           = owner_q;
    req_addr_d        = req_addr_q;
    req_fcn_d         = req_fcn_q;
    req_typ_d         = req_typ_q;
    req_wdata_d       = req_wdata_q;
    resp_data_d       = resp_data_q;
    imem_resp_valid_d = 1'b0;
    dmem_resp_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (grant_imem) begin
          // Fetches are always full-word reads.
          req_addr_d   = imem_req_addr;
          req_fcn_d    = M_XRD;
          req_typ_d    = MT_WU;
          req_wdata_d  = '0;
          owner_d      = SelImem;
          last_grant_d = SelImem;
          state_d      = StIssue;
        end else if (grant_dmem) begin
          req_addr_d   = dmem_req_addr;
          req_fcn_d    = dmem_req_fcn;
          req_typ_d    = dmem_req_typ;
          req_wdata_d  = dmem_req_wdata;
          owner_d      = SelDmem;
          last_grant_d = SelDmem;
          state_d      = StIssue;
        end
      end
      StIssue: begin
        // A response seen before the request is accepted is not ours.
        if (mem_req_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (mem_resp_valid) begin
          resp_data_d = mem_resp_data;
          if (owner_q == SelDmem) begin
            dmem_resp_valid_d = 1'b1;
          end else begin
            imem_resp_valid_d = 1'b1;
          end
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q           <= StIdle;
      last_grant_q      <= SelDmem;
      owner_q           <= SelImem;
      req_addr_q        <= '0;
      req_fcn_q         <= 1'b0;
      req_typ_q         <= 3'd0;
      req_wdata_q       <= '0;
      resp_data_q       <= '0;
      imem_resp_valid_q <= 1'b0;
      dmem_resp_valid_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      last_grant_q      <= last_grant_d;
      owner_q           <= owner_d;
      req_addr_q        <= req_addr_d;
      req_fcn_q         <= req_fcn_d;
      req_typ_q         <= req_typ_d;
      req_wdata_q       <= req_wdata_d;
      resp_data_q       <= resp_data_d;
      imem_resp_valid_q <= imem_resp_valid_d;
      dmem_resp_valid_q <= dmem_resp_valid_d;
    end
  end

  // Shared-port request is a pure function of registered state.
  assign mem_req_valid   = (state_q == StIssue);
  assign mem_req_addr    = req_addr_q;
  assign mem_req_fcn     = req_fcn_q;
  assign mem_req_typ     = req_typ_q;
  assign mem_req_wdata   = req_wdata_q;

  assign imem_resp_valid = imem_resp_valid_q;
  assign dmem_resp_valid = dmem_resp_valid_q;
  assign imem_resp_data  = resp_data_q;
  assign dmem_resp_data  = resp_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk;
  logic              reset;
  logic              imem_req_valid;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_req_ready;
  logic              imem_resp_valid;
  logic [DATA_W-1:0] imem_resp_data;
  logic              dmem_req_valid;
  logic [ADDR_W-1:0] dmem_req_addr;
  logic              dmem_req_fcn;
  logic [2:0]        dmem_req_typ;
  logic [DATA_W-1:0] dmem_req_wdata;
  logic              dmem_req_ready;
  logic              dmem_resp_valid;
  logic [DATA_W-1:0] dmem_resp_data;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_fcn;
  logic [2:0]        mem_req_typ;
  logic [DATA_W-1:0] mem_req_wdata;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;

  mem_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_addr  (dmem_req_addr),
    .dmem_req_fcn   (dmem_req_fcn),
    .dmem_req_typ   (dmem_req_typ),
    .dmem_req_wdata (dmem_req_wdata),
    .dmem_req_ready (dmem_req_ready),
    .dmem_resp_valid(dmem_resp_valid),
    .dmem_resp_data (dmem_resp_data),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_fcn    (mem_req_fcn),
    .mem_req_typ    (mem_req_typ),
    .mem_req_wdata  (mem_req_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Transaction-level reference: one outstanding request, its phase
  // (waiting for port acceptance or for the response), and the pulse due.
  bit          m_busy;
  bit          m_issued;
  bit          m_last;       // 1: dmem won last
  bit          m_owner;      // 1: dmem
  logic [31:0] m_addr;
  logic        m_fcn;
  logic [2:0]  m_typ;
  logic [31:0] m_wdata;
  logic [31:0] m_resp_data;
  bit          m_pulse_i;
  bit          m_pulse_d;
  int          mem_cd;

  // Observations taken from the DUT for scenario-level checks.
  int order[$];
  bit b2b_seen;
  int n_ipulse;
  int n_dpulse;
  int n_mvalid;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy      = 0;
    m_issued    = 0;
    m_last      = 1;
    m_owner     = 0;
    m_addr      = '0;
    m_fcn       = 1'b0;
    m_typ       = 3'd0;
    m_wdata     = '0;
    m_resp_data = '0;
    m_pulse_i   = 0;
    m_pulse_d   = 0;
  endtask

  task automatic idle_inputs();
    imem_req_valid = 1'b0;
    imem_req_addr  = '0;
    dmem_req_valid = 1'b0;
    dmem_req_addr  = '0;
    dmem_req_fcn   = 1'b0;
    dmem_req_typ   = 3'd0;
    dmem_req_wdata = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
  endtask

  // One clock cycle: compare at the falling edge, advance the model, return
  // just after the next rising edge so the caller can drive new inputs.
  task automatic tick();
    bit gi;
    bit gd;
    @(negedge clk);
    gi = !m_busy && imem_req_valid && (!dmem_req_valid || m_last);
    gd = !m_busy && dmem_req_valid && (!imem_req_valid || !m_last);
    chk("imem_req_ready", imem_req_ready, gi);
    chk("dmem_req_ready", dmem_req_ready, gd);
    chk("mem_req_valid", mem_req_valid, m_busy && !m_issued);
    chk("mem_req_addr", mem_req_addr, m_addr);
    chk("mem_req_fcn", mem_req_fcn, m_fcn);
    chk("mem_req_typ", mem_req_typ, m_typ);
    chk("mem_req_wdata", mem_req_wdata, m_wdata);
    chk("imem_resp_valid", imem_resp_valid, m_pulse_i);
    chk("dmem_resp_valid", dmem_resp_valid, m_pulse_d);
    chk("imem_resp_data", imem_resp_data, m_resp_data);
    chk("dmem_resp_data", dmem_resp_data, m_resp_data);

    if (imem_req_ready === 1'b1) order.push_back(0);
    if (dmem_req_ready === 1'b1) order.push_back(1);
    if (dmem_resp_valid === 1'b1 && dmem_req_ready === 1'b1) b2b_seen = 1;
    if (imem_resp_valid === 1'b1) n_ipulse++;
    if (dmem_resp_valid === 1'b1) n_dpulse++;
    if (mem_req_valid === 1'b1) n_mvalid++;

    if (!reset) begin
      model_reset();
    end else begin
      m_pulse_i = 0;
      m_pulse_d = 0;
      if (gi) begin
        m_addr = imem_req_addr; m_fcn = 1'b0; m_typ = 3'd6; m_wdata = '0;
        m_busy = 1; m_issued = 0; m_last = 0; m_owner = 0;
      end else if (gd) begin
        m_addr = dmem_req_addr; m_fcn = dmem_req_fcn; m_typ = dmem_req_typ;
        m_wdata = dmem_req_wdata;
        m_busy = 1; m_issued = 0; m_last = 1; m_owner = 1;
      end else if (m_busy && !m_issued && mem_req_ready) begin
        m_issued = 1;
        mem_cd   = int'($urandom_range(1, 4));
      end else if (m_busy && m_issued && mem_resp_valid) begin
        m_resp_data = mem_resp_data;
        if (m_owner) m_pulse_d = 1; else m_pulse_i = 1;
        m_busy = 0;
        m_issued = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, observed=running required=finished");
    $fatal(1);
  end

  initial begin
    int base_i;
    int base_d;

    // Reset: both requesting, imem must be the one offered ready.
    idle_inputs();
    model_reset();
    reset = 1'b0;
    imem_req_valid = 1'b1;
    dmem_req_valid = 1'b1;
    tick();
    tick();
    idle_inputs();
    reset = 1'b1;
    tick();

    // Single fetch, L=2.
    base_d = n_dpulse;
    base_i = n_ipulse;
    imem_req_valid = 1'b1; imem_req_addr = 32'h100; mem_req_ready = 1'b1;
    tick();                                   // cycle 0: accept
    imem_req_valid = 1'b0;
    tick();                                   // cycle 1: mem_req_valid
    tick();                                   // cycle 2
    mem_resp_valid = 1'b1; mem_resp_data = 32'hDEADBEEF;
    tick();                                   // cycle 3: response
    mem_resp_valid = 1'b0;
    tick();                                   // cycle 4: pulse
    chk("fetch_pulse_count", n_ipulse - base_i, 1);
    chk("fetch_no_dmem_pulse", n_dpulse - base_d, 0);
    tick();

    // Simultaneous requests from reset.
    reset = 1'b0;
    model_reset();
    tick();
    reset = 1'b1;
    order.delete();
    imem_req_valid = 1'b1; imem_req_addr = 32'h400;
    dmem_req_valid = 1'b1; dmem_req_addr = 32'h800;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      mem_resp_data = $urandom;
      tick();
    end
    idle_inputs();
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 32'h1234;
    repeat (4) tick();
    mem_resp_valid = 1'b0;
    tick();
    chk("rr_order_len_ge4", order.size() >= 4, 1);
    if (order.size() >= 4) begin
      chk("rr_order0", order[0], 0);
      chk("rr_order1", order[1], 1);
      chk("rr_order2", order[2], 0);
      chk("rr_order3", order[3], 1);
    end

    // Store with backpressure.
    idle_inputs();
    base_d = n_dpulse;
    dmem_req_valid = 1'b1; dmem_req_fcn = 1'b1; dmem_req_addr = 32'h2004;
    dmem_req_wdata = 32'h55AA; dmem_req_typ = 3'd2;
    tick();                                   // accept
    dmem_req_valid = 1'b0;
    n_mvalid = 0;
    repeat (3) tick();                        // stalled in issue
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("store_req_held_cycles", n_mvalid, 4);
    tick();
    mem_resp_valid = 1'b1; mem_resp_data = 32'hA5A5_0F0F;
    tick();
    mem_resp_valid = 1'b0;
    repeat (3) tick();
    chk("store_pulse_count", n_dpulse - base_d, 1);

    // Spurious responses while idle and while issuing.
    base_i = n_ipulse;
    base_d = n_dpulse;
    mem_resp_valid = 1'b1; mem_resp_data = 32'hBAD0_0001;
    repeat (3) tick();
    mem_resp_valid = 1'b0;
    imem_req_valid = 1'b1; imem_req_addr = 32'h3000;
    tick();
    imem_req_valid = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'hBAD0_0002;
    repeat (2) tick();
    chk("spurious_no_pulse", (n_ipulse - base_i) + (n_dpulse - base_d), 0);
    mem_resp_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h600D_F00D;
    tick();
    mem_resp_valid = 1'b0;
    tick();
    chk("spurious_real_pulse", n_ipulse - base_i, 1);

    // Reset mid-WAIT: late response must not surface.
    imem_req_valid = 1'b1; imem_req_addr = 32'h5000; mem_req_ready = 1'b1;
    tick();
    imem_req_valid = 1'b0;
    tick();                                   // port accepts, now waiting
    mem_req_ready = 1'b0;
    reset = 1'b0;
    model_reset();
    tick();
    reset = 1'b1;
    base_i = n_ipulse;
    mem_resp_valid = 1'b1; mem_resp_data = 32'h1A7E_1A7E;
    tick();
    mem_resp_valid = 1'b0;
    repeat (2) tick();
    chk("reset_wait_no_pulse", n_ipulse - base_i, 0);
    imem_req_valid = 1'b1; imem_req_addr = 32'h5004; mem_req_ready = 1'b1;
    tick();
    imem_req_valid = 1'b0;
    tick();
    mem_resp_valid = 1'b1; mem_resp_data = 32'h0BAD_CAFE;
    tick();
    mem_resp_valid = 1'b0;
    tick();
    chk("reset_wait_next_pulse", n_ipulse - base_i, 1);

    // Back-to-back dmem reads.
    idle_inputs();
    b2b_seen = 0;
    dmem_req_valid = 1'b1; dmem_req_addr = 32'h7000; dmem_req_typ = 3'd3;
    mem_req_ready = 1'b1; mem_resp_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      mem_resp_data = $urandom;
      tick();
      dmem_req_addr = dmem_req_addr + 32'd4;
    end
    dmem_req_valid = 1'b0;
    repeat (4) tick();
    mem_resp_valid = 1'b0;
    tick();
    chk("b2b_accept_on_pulse", b2b_seen, 1);

    // Randomized traffic against the reference model.
    idle_inputs();
    for (int i = 0; i < 3000; i++) begin
      imem_req_valid = 1'($urandom_range(0, 1));
      imem_req_addr  = $urandom;
      dmem_req_valid = 1'($urandom_range(0, 1));
      dmem_req_addr  = $urandom;
      dmem_req_fcn   = 1'($urandom_range(0, 1));
      dmem_req_typ   = 3'($urandom_range(1, 6));
      dmem_req_wdata = $urandom;
      mem_req_ready  = ($urandom_range(0, 3) != 0);
      mem_resp_data  = $urandom;
      if (m_busy && m_issued) begin
        mem_cd--;
        mem_resp_valid = (mem_cd <= 0);
      end else begin
        mem_resp_valid = ($urandom_range(0, 7) == 0);
      end
      tick();
    end
    idle_inputs();
    mem_req_ready = 1'b1;
    mem_resp_valid = 1'b1;
    repeat (6) tick();
    idle_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
